// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle: line requests with byte-masked write data,
// and fixed-latency read responses. The cache drives master; the memory responder is slave.
interface mem_responder_if #(
   parameter int unsigned MEM_DATA_BITS = 128,
   parameter int unsigned ADDR_BITS     = 28
);
   logic                       mem_req_valid;
   logic                       mem_req_ready;
   logic [ADDR_BITS-1:0]       mem_req_addr;
   logic                       mem_req_rw;
   logic                       mem_req_data_valid;
   logic                       mem_req_data_ready;
   logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
   logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
   logic                       mem_resp_valid;
   logic [MEM_DATA_BITS-1:0]   mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_rw,
             mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
      input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_rw,
             mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
      output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/mem_responder.sv
// Behavioural backing store below the cache: in-order fixed-latency pipeline feeding a
// byte-maskable line array, with an optional post-acceptance ready gap.
module mem_responder #(
   parameter int unsigned MEM_DATA_BITS = 128,
   parameter int unsigned ADDR_BITS     = 28,
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned LATENCY       = 4,
   parameter int unsigned READY_GAP     = 0
) (
   input  logic      clk,
   input  logic      reset_n,
   mem_responder_if.slave mem
);
   localparam int unsigned MASK_BITS = MEM_DATA_BITS / 8;
   localparam int unsigned IDX_BITS  = $clog2(DEPTH);
   localparam logic [3:0]  GAP_LOAD  = 4'(READY_GAP);

   typedef struct packed {
      logic                     vld;
      logic                     rw;
      logic [IDX_BITS-1:0]      idx;
      logic [MEM_DATA_BITS-1:0] data;
      logic [MASK_BITS-1:0]     mask;
   } req_t;

   logic                     ready_q, ready_d;
   logic [3:0]               gap_q, gap_d;
   logic                     accept;
   req_t                     in_req;
   req_t                     exit_req;
   logic                     resp_valid_q, resp_valid_d;
   logic [MEM_DATA_BITS-1:0] resp_data_q, resp_data_d;
   logic [MEM_DATA_BITS-1:0] mem_q [DEPTH];

   always_comb begin
      accept = mem.mem_req_valid & ready_q & (~mem.mem_req_rw | mem.mem_req_data_valid);

      in_req      = '0;
      in_req.vld  = accept;
      in_req.rw   = mem.mem_req_rw;
      in_req.idx  = mem.mem_req_addr[IDX_BITS-1:0];
      in_req.data = mem.mem_req_data_bits;
      in_req.mask = mem.mem_req_data_mask;
   end

   if (ADDR_BITS > IDX_BITS) begin : g_alias
      logic unused_addr_hi;
      always_comb unused_addr_hi = ^mem.mem_req_addr[ADDR_BITS-1:IDX_BITS];
   end

   // Ready is registered from the post-update gap count so it never sees this cycle's valid.
   always_comb begin
      gap_d = gap_q;
      if (accept) begin
         gap_d = GAP_LOAD;
      end else if (gap_q != 4'd0) begin
         gap_d = gap_q - 4'd1;
      end
      ready_d = (gap_d == 4'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q <= 1'b0;
         gap_q   <= '0;
      end else begin
         ready_q <= ready_d;
         gap_q   <= gap_d;
      end
   end

   // The accepting cycle counts as stage 0, so only LATENCY-1 register stages are needed;
   // the exit stage acts at the end of cycle t+LATENCY-1 and the response register lands at t+LATENCY.
   if (LATENCY > 1) begin : g_pipe
      req_t pipe_q [LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int unsigned i = 0; i < LATENCY - 1; i++) begin
               pipe_q[i] <= '0;
            end
         end else begin
            pipe_q[0] <= in_req;
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end

      always_comb exit_req = pipe_q[LATENCY-2];
   end else begin : g_bypass
      always_comb exit_req = in_req;
   end

   always_comb begin
      resp_valid_d = exit_req.vld & ~exit_req.rw;
      resp_data_d  = resp_data_q;
      if (resp_valid_d) begin
         resp_data_d = mem_q[exit_req.idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // Array contents survive reset; only the exit-stage valid gates commits.
   always_ff @(posedge clk) begin
      if (exit_req.vld && exit_req.rw) begin
         for (int unsigned b = 0; b < MASK_BITS; b++) begin
            if (exit_req.mask[b]) begin
               mem_q[exit_req.idx][8*b +: 8] <= exit_req.data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      mem.mem_req_ready      = ready_q;
      mem.mem_req_data_ready = ready_q;
      mem.mem_resp_valid     = resp_valid_q;
      mem.mem_resp_data      = resp_data_q;
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: requests push expected read data and arrival cycle
// into a scoreboard; a negedge monitor pops and compares every response pulse.
module tb_mem_responder;
   localparam int unsigned DW = 128;
   localparam int unsigned AW = 28;
   localparam int unsigned LAT = 4;

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int          gap_resps = 0;
   exp_t        sbq[$];
   exp_t        e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) bus ();
   mem_responder_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) bus_g ();

   mem_responder #(
      .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .DEPTH(256), .LATENCY(LAT), .READY_GAP(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mem(bus)
   );

   mem_responder #(
      .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .DEPTH(256), .LATENCY(LAT), .READY_GAP(2)
   ) dut_gap (
      .clk(clk), .reset_n(reset_n), .mem(bus_g)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected no response", cyc);
            end else begin
               e = sbq.pop_front();
               check("resp_data", bus.mem_resp_data, e.data);
               check("resp_cycle", DW'(cyc), DW'(e.cyc));
            end
         end
      end
   end

   always @(negedge clk) if (bus_g.mem_resp_valid === 1'b1) gap_resps++;

   task automatic idle();
      bus.mem_req_valid      = 1'b0;
      bus.mem_req_rw         = 1'b0;
      bus.mem_req_addr       = '0;
      bus.mem_req_data_valid = 1'b0;
      bus.mem_req_data_bits  = '0;
      bus.mem_req_data_mask  = '0;
   endtask

   // Entered and left at a negedge; the request is held until the bench-predicted acceptance.
   task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [15:0] mask, input logic [DW-1:0] exp, input bit push,
                      input int stall);
      bit done = 0;
      bus.mem_req_valid = 1'b1;
      bus.mem_req_rw    = rw;
      bus.mem_req_addr  = addr;
      for (int n = 0; n < 20 && !done; n++) begin
         if (rw && n < stall) begin
            bus.mem_req_data_valid = 1'b0;
            bus.mem_req_data_bits  = {16{8'hEE}};
            bus.mem_req_data_mask  = 16'hFFFF;
         end else begin
            bus.mem_req_data_valid = rw;
            bus.mem_req_data_bits  = data;
            bus.mem_req_data_mask  = mask;
         end
         #1;
         if (rw && n < stall) begin
            check("ready_during_stall", DW'(bus.mem_req_ready), DW'(1'b1));
         end else if (bus.mem_req_ready === 1'b1) begin
            done = 1;
            if (!rw && push) sbq.push_back('{exp, cyc + LAT});
         end
         @(negedge clk);
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL req_timeout: got no acceptance for addr %h expected acceptance", addr);
      end
      idle();
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
      end
   endtask

   localparam logic [DW-1:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF01234567FFFFFFFF;

   initial begin
      idle();
      bus_g.mem_req_valid      = 1'b0;
      bus_g.mem_req_rw         = 1'b0;
      bus_g.mem_req_addr       = '0;
      bus_g.mem_req_data_valid = 1'b0;
      bus_g.mem_req_data_bits  = '0;
      bus_g.mem_req_data_mask  = '0;

      repeat (3) @(negedge clk);
      check("rst_ready", DW'(bus.mem_req_ready), '0);
      check("rst_data_ready", DW'(bus.mem_req_data_ready), '0);
      check("rst_resp_valid", DW'(bus.mem_resp_valid), '0);
      check("rst_resp_data", bus.mem_resp_data, '0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", DW'(bus.mem_req_ready), DW'(1'b1));
      check("post_rst_data_ready", DW'(bus.mem_req_data_ready), DW'(1'b1));

      req(1'b1, 28'h5, D0, 16'hFFFF, '0, 0, 0);
      req(1'b0, 28'h5, '0, '0, D0, 1, 0);
      req(1'b1, 28'h5, '1, 16'h000F, '0, 0, 0);
      req(1'b0, 28'h5, '0, '0, D1, 1, 0);
      drain();

      req(1'b1, 28'h8, {16{8'h88}}, 16'hFFFF, '0, 0, 0);
      req(1'b1, 28'h9, {16{8'h99}}, 16'hFFFF, '0, 0, 0);
      req(1'b1, 28'hA, {16{8'hAA}}, 16'hFFFF, '0, 0, 0);
      req(1'b1, 28'hB, {16{8'hBB}}, 16'hFFFF, '0, 0, 0);
      req(1'b0, 28'h8, '0, '0, {16{8'h88}}, 1, 0);
      req(1'b0, 28'h9, '0, '0, {16{8'h99}}, 1, 0);
      req(1'b0, 28'hA, '0, '0, {16{8'hAA}}, 1, 0);
      req(1'b0, 28'hB, '0, '0, {16{8'hBB}}, 1, 0);
      drain();

      req(1'b1, 28'h8, '0, 16'h0000, '0, 0, 0);
      req(1'b0, 28'h8, '0, '0, {16{8'h88}}, 1, 0);
      req(1'b1, 28'h9, '0, 16'hF0F0, '0, 0, 0);
      req(1'b0, 28'h9, '0, '0, 128'h00000000999999990000000099999999, 1, 0);
      req(1'b1, 28'hABCDE0C, {16{8'hC3}}, 16'hFFFF, '0, 0, 0);
      req(1'b0, 28'h00C, '0, '0, {16{8'hC3}}, 1, 0);
      drain();

      req(1'b1, 28'h20, {16{8'h11}}, 16'hFFFF, '0, 0, 0);
      req(1'b1, 28'h20, {16{8'h55}}, 16'h00FF, '0, 0, 3);
      req(1'b0, 28'h20, '0, '0, 128'h11111111111111115555555555555555, 1, 0);
      drain();

      bus_g.mem_req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("gap_ready_%0d", i), DW'(bus_g.mem_req_ready), DW'((i % 3) == 0));
         @(negedge clk);
      end
      bus_g.mem_req_valid = 1'b0;
      #1;
      check("gap_ready_after", DW'(bus_g.mem_req_ready), DW'(1'b1));
      repeat (8) @(negedge clk);
      check("gap_resp_count", DW'(gap_resps), DW'(2));

      req(1'b1, 28'h5, {16{8'h77}}, 16'hFFFF, '0, 0, 0);
      req(1'b0, 28'h8, '0, '0, '0, 0, 0);
      req(1'b0, 28'h9, '0, '0, '0, 0, 0);
      reset_n = 1'b0;
      #1;
      check("midrst_ready", DW'(bus.mem_req_ready), '0);
      check("midrst_data_ready", DW'(bus.mem_req_data_ready), '0);
      check("midrst_resp_valid", DW'(bus.mem_resp_valid), '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check("after_midrst_ready", DW'(bus.mem_req_ready), DW'(1'b1));
      req(1'b0, 28'h5, '0, '0, D1, 1, 0);
      req(1'b0, 28'h8, '0, '0, {16{8'h88}}, 1, 0);
      drain();
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
